// File: rtl/centroid_pkg.sv
`default_nettype none
// ============================================================================
// Module   : centroid_pkg
// Purpose  : Shared state encoding and width helpers for the centroid tracker.
// Revision : 1.0 - initial release
// ============================================================================
package centroid_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DIVIDE = 2'd2,
        DONE   = 2'd3
    } state_e;

    // A zero threshold would allow a zero divisor, so it is lifted to one.
    function automatic int unsigned eff_min_count(input int unsigned min_count);
        return (min_count == 0) ? 1 : min_count;
    endfunction

    // Bits needed to hold sum(0..n-1) without wrapping.
    function automatic int unsigned sum_width(input int unsigned n_pix);
        return $clog2((n_pix * (n_pix - 1)) / 2 + 1);
    endfunction

endpackage : centroid_pkg
`default_nettype wire

// File: rtl/serial_divider.sv
`default_nettype none
// ============================================================================
// Module   : serial_divider
// Purpose  : Unsigned restoring divider, one quotient bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
module serial_divider #(
    parameter int DVD_W = 18,
    parameter int DVS_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [DVD_W-1:0] quotient
);

    localparam int ITER_W = $clog2(DVD_W + 1);

    logic [DVS_W-1:0]  rem_q,  rem_d;
    logic [DVD_W-1:0]  work_q, work_d;
    logic [DVS_W-1:0]  dvs_q,  dvs_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [DVS_W-1:0]  w_src_rem;
    logic [DVD_W-1:0]  w_src_work;
    logic [DVS_W-1:0]  w_src_dvs;
    logic [DVS_W:0]    w_trial;
    logic [DVS_W:0]    w_diff;
    logic              w_ge;
    logic              w_diff_unused;

    // The start cycle already performs the first iteration, so a full
    // divide takes exactly DVD_W clocks from start to the done pulse.
    always_comb begin
        w_src_rem  = start ? '0       : rem_q;
        w_src_work = start ? dividend : work_q;
        w_src_dvs  = start ? divisor  : dvs_q;
        w_trial    = {w_src_rem, w_src_work[DVD_W-1]};
        w_ge       = (w_trial >= {1'b0, w_src_dvs});
        w_diff     = w_ge ? (w_trial - {1'b0, w_src_dvs}) : w_trial;
    end

    // The partial remainder is always below the divisor, so the top bit is zero.
    assign w_diff_unused = w_diff[DVS_W];

    always_comb begin
        rem_d  = rem_q;
        work_d = work_q;
        dvs_d  = dvs_q;
        iter_d = iter_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            rem_d  = w_diff[DVS_W-1:0];
            work_d = {w_src_work[DVD_W-2:0], w_ge};
            dvs_d  = divisor;
            iter_d = ITER_W'(DVD_W - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d  = w_diff[DVS_W-1:0];
            work_d = {w_src_work[DVD_W-2:0], w_ge};
            iter_d = iter_q - ITER_W'(1);
            if (iter_q == ITER_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            work_q <= '0;
            dvs_q  <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            work_q <= work_d;
            dvs_q  <= dvs_d;
            iter_q <= iter_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done     = done_q;
    assign quotient = work_q;

endmodule : serial_divider
`default_nettype wire

// File: rtl/centroid_tracker.sv
`default_nettype none
// ============================================================================
// Module   : centroid_tracker
// Purpose  : Streaming floor-average index of set pixels on one mask line.
// Revision : 1.0 - initial release
// ============================================================================
module centroid_tracker
    import centroid_pkg::*;
#(
    parameter int N_PIX     = 480,
    parameter int IDX_W     = 10,
    parameter int SUM_W     = 18,
    parameter int CNT_W     = 10,
    parameter int MIN_COUNT = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic             pix_first,
    input  logic             pix_last,
    input  logic             pix_bit,
    output logic [IDX_W-1:0] center,
    output logic             center_valid,
    output logic             found,
    output logic [CNT_W-1:0] pix_count
);

    localparam logic [CNT_W-1:0] c_min_cnt  = CNT_W'(eff_min_count(MIN_COUNT));
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_PIX - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ovf_q, ovf_d;
    logic [SUM_W-1:0] w_sum_q, w_sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] center_q, center_d;
    logic             found_q, found_d;
    logic [CNT_W-1:0] pix_count_q, pix_count_d;

    logic             w_ready;
    logic             w_take;
    logic [IDX_W-1:0] w_beat_idx;
    logic             w_beat_ovf;
    logic [SUM_W-1:0] w_base_sum;
    logic [CNT_W-1:0] w_base_cnt;
    logic             w_acc;
    logic             w_at_end;
    logic [SUM_W-1:0] w_sum_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [IDX_W-1:0] w_idx_nx;
    logic             w_ovf_nx;
    logic             w_found_nx;
    logic             w_div_start;
    logic             w_div_done;
    logic [SUM_W-1:0] w_quot;
    logic             w_quot_unused;

    assign w_ready = (state_q == IDLE) || (state_q == ACCUM);
    // A beat belongs to a line if it opens one or arrives while one is open.
    assign w_take  = pix_valid && w_ready && (pix_first || (state_q == ACCUM));

    // A pix_first beat restarts from index 0 with cleared accumulators.
    always_comb begin
        w_beat_idx = pix_first ? '0   : idx_q;
        w_beat_ovf = pix_first ? 1'b0 : ovf_q;
        w_base_sum = pix_first ? '0   : w_sum_q;
        w_base_cnt = pix_first ? '0   : cnt_q;
        w_acc      = pix_bit && !w_beat_ovf;
        w_sum_nx   = w_base_sum + (w_acc ? SUM_W'(w_beat_idx) : '0);
        w_cnt_nx   = w_base_cnt + (w_acc ? CNT_W'(1) : '0);
        w_at_end   = (w_beat_idx == c_last_idx);
        w_idx_nx   = w_at_end ? w_beat_idx : (w_beat_idx + IDX_W'(1));
        w_ovf_nx   = w_beat_ovf || w_at_end;
        w_found_nx = (w_cnt_nx >= c_min_cnt);
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ovf_d       = ovf_q;
        w_sum_d     = w_sum_q;
        cnt_d       = cnt_q;
        center_d    = center_q;
        found_d     = found_q;
        pix_count_d = pix_count_q;
        w_div_start = 1'b0;
        case (state_q)
            IDLE, ACCUM: begin
                if (w_take) begin
                    idx_d   = w_idx_nx;
                    ovf_d   = w_ovf_nx;
                    w_sum_d = w_sum_nx;
                    cnt_d   = w_cnt_nx;
                    state_d = ACCUM;
                    if (pix_last) begin
                        if (w_found_nx) begin
                            state_d     = DIVIDE;
                            w_div_start = 1'b1;
                        end else begin
                            state_d     = DONE;
                            found_d     = 1'b0;
                            pix_count_d = w_cnt_nx;
                        end
                    end
                end
            end
            DIVIDE: begin
                if (w_div_done) begin
                    state_d     = DONE;
                    found_d     = 1'b1;
                    center_d    = w_quot[IDX_W-1:0];
                    pix_count_d = cnt_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            ovf_q       <= 1'b0;
            w_sum_q     <= '0;
            cnt_q       <= '0;
            center_q    <= '0;
            found_q     <= 1'b0;
            pix_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ovf_q       <= ovf_d;
            w_sum_q     <= w_sum_d;
            cnt_q       <= cnt_d;
            center_q    <= center_d;
            found_q     <= found_d;
            pix_count_q <= pix_count_d;
        end
    end

    // The divider sees the accumulators including the final beat.
    serial_divider #(
        .DVD_W (SUM_W),
        .DVS_W (CNT_W)
    ) u_div (
        .clk      (Clk),
        .rst      (Reset),
        .start    (w_div_start),
        .dividend (w_sum_nx),
        .divisor  (w_cnt_nx),
        .done     (w_div_done),
        .quotient (w_quot)
    );

    // The average index never exceeds N_PIX-1, so the upper quotient bits stay zero.
    assign w_quot_unused = ^w_quot[SUM_W-1:IDX_W];

    assign pix_ready    = w_ready;
    assign center       = center_q;
    assign center_valid = (state_q == DONE);
    assign found        = found_q;
    assign pix_count    = pix_count_q;

endmodule : centroid_tracker
`default_nettype wire

// File: tb/tb_centroid_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_centroid_tracker
// Purpose  : Self-checking bench for centroid_tracker using a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_centroid_tracker;

    localparam int SUM_W = 18;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       pix_valid;
    logic       pix_ready;
    logic       pix_first;
    logic       pix_last;
    logic       pix_bit;
    logic [9:0] center;
    logic       center_valid;
    logic       found;
    logic [9:0] pix_count;

    typedef struct {
        int len;
        int p0;
        int p1;
        bit all_ones;
        int e_center;
        int e_found;
        int e_count;
    } vec_t;

    typedef struct {
        int center;
        int found;
        int count;
        int cyc;
    } exp_t;

    vec_t vecs[11];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    centroid_tracker dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_first    (pix_first),
        .pix_last     (pix_last),
        .pix_bit      (pix_bit),
        .center       (center),
        .center_valid (center_valid),
        .found        (found),
        .pix_count    (pix_count)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one beat and hold it until it transfers.
    task automatic send_beat(input bit first, input bit last, input bit b);
        int guard = 0;
        pix_valid = 1'b1;
        pix_first = first;
        pix_last  = last;
        pix_bit   = b;
        while (!pix_ready && guard < 100) begin
            @(posedge Clk);
            #1;
            guard++;
        end
        if (guard >= 100) check("ready_timeout", 0, 1);
        @(posedge Clk);
        #1;
    endtask

    task automatic push_exp(input int c, input int f, input int n);
        exp_t e;
        e.center = c;
        e.found  = f;
        e.count  = n;
        e.cyc    = cyc - 1;
        sb.push_back(e);
    endtask

    task automatic send_line(input vec_t v, input bit push);
        for (int i = 0; i < v.len; i++) begin
            send_beat(i == 0, i == v.len - 1, v.all_ones || i == v.p0 || i == v.p1);
        end
        if (push) push_exp(v.e_center, v.e_found, v.e_count);
        check("ready_low_after_last", int'(pix_ready), 0);
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(posedge Clk);
            guard++;
        end
        check("drain", sb.size(), 0);
    endtask

    always @(negedge Clk) begin
        if (!Reset && center_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("center",    int'(center),    e.center);
                check("found",     int'(found),     e.found);
                check("pix_count", int'(pix_count), e.count);
                check("latency",   cyc - e.cyc,     (e.found != 0) ? SUM_W + 1 : 1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t", $time);
        $fatal(1);
    end

    initial begin
        vec_t v;
        vecs[0]  = '{480, -1,  -1, 1'b1, 239, 1, 480};
        vecs[1]  = '{480,  0, 479, 1'b0, 239, 1,   2};
        vecs[2]  = '{480, 100, -1, 1'b0, 100, 1,   1};
        vecs[3]  = '{480, -1,  -1, 1'b0, 100, 0,   0};
        vecs[4]  = '{ 64, 10,  20, 1'b0,  15, 1,   2};
        vecs[5]  = '{  8,  3,   4, 1'b0,   3, 1,   2};
        vecs[6]  = '{  1,  0,  -1, 1'b0,   0, 1,   1};
        vecs[7]  = '{  1, -1,  -1, 1'b0,   0, 0,   0};
        vecs[8]  = '{600, 479, 550, 1'b0, 479, 1,  1};
        vecs[9]  = '{600, -1,  -1, 1'b1, 239, 1, 480};
        vecs[10] = '{ 20, 19,  -1, 1'b0,  19, 1,   1};

        Reset     = 1'b1;
        pix_valid = 1'b0;
        pix_first = 1'b0;
        pix_last  = 1'b0;
        pix_bit   = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_center",       int'(center),       0);
        check("rst_found",        int'(found),        0);
        check("rst_pix_count",    int'(pix_count),    0);
        check("rst_center_valid", int'(center_valid), 0);
        check("rst_pix_ready",    int'(pix_ready),    1);
        Reset = 1'b0;

        // Beats without pix_first while idle must be dropped silently.
        repeat (3) send_beat(1'b0, 1'b1, 1'b1);
        pix_valid = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        check("idle_discard_ready", int'(pix_ready), 1);

        // Lines back to back: the next line waits on pix_ready.
        foreach (vecs[i]) send_line(vecs[i], 1'b1);
        pix_valid = 1'b0;
        drain();

        // Restart mid-line: the partial line with a pixel at 30 is dropped.
        send_beat(1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 200; i++) send_beat(1'b0, 1'b0, i == 30);
        for (int j = 0; j < 100; j++) send_beat(j == 0, j == 99, j == 50);
        push_exp(50, 1, 1);
        pix_valid = 1'b0;
        drain();

        // Reset during the divide aborts the line with no result pulse.
        v = '{10, 5, -1, 1'b0, 5, 1, 1};
        send_line(v, 1'b0);
        pix_valid = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        check("abort_center",       int'(center),       0);
        check("abort_found",        int'(found),        0);
        check("abort_pix_count",    int'(pix_count),    0);
        check("abort_center_valid", int'(center_valid), 0);
        check("abort_pix_ready",    int'(pix_ready),    1);
        repeat (30) @(posedge Clk);
        #1;

        v = '{16, 7, -1, 1'b0, 7, 1, 1};
        send_line(v, 1'b1);
        pix_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_centroid_tracker
`default_nettype wire
